// File: rtl/nibble_serial_adder_if.sv
// Operand, result and adder-slice signals of the nibble-serial adder.
// The slave side is the controller; the master side drives operands and models the slice.
interface nibble_serial_adder_if;
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;

  logic          run;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic [NW-1:0] slice_a_c;
  logic [NW-1:0] slice_b_c;
  logic          slice_cin_c;
  logic [NW-1:0] slice_sum;
  logic          slice_cout;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic          busy;
  logic          done;

  modport slave (
    input  run, a, b, sub, slice_sum, slice_cout,
    output slice_a_c, slice_b_c, slice_cin_c, sum, cout, overflow, busy, done
  );

  modport master (
    output run, a, b, sub, slice_sum, slice_cout,
    input  slice_a_c, slice_b_c, slice_cin_c, sum, cout, overflow, busy, done
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// 16-bit add/subtract that time-shares one external 4-bit adder slice,
// LSB nibble first, carrying between slices in a flop.
module nibble_serial_adder (
  input  logic                  clk_i,
  input  logic                  rst_i,
  nibble_serial_adder_if.slave  bus_io
);
  localparam int unsigned W  = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned AW = W - NW;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sub_q, sub_d;
  logic           carry_q, carry_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [NW-1:0]  a_nib, b_nib;
  logic           b_msb;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;

    a_nib = a_q[{cnt_q, 2'b00} +: NW];
    b_nib = b_q[{cnt_q, 2'b00} +: NW] ^ {NW{sub_q}};
    b_msb = b_q[W-1] ^ sub_q;

    // Slice is only driven while consuming nibbles; quiet otherwise.
    bus_io.slice_a_c   = '0;
    bus_io.slice_b_c   = '0;
    bus_io.slice_cin_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_io.run) begin
          state_d = ADD;
          a_d     = bus_io.a;
          b_d     = bus_io.b;
          sub_d   = bus_io.sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ADD: begin
        bus_io.slice_a_c   = a_nib;
        bus_io.slice_b_c   = b_nib;
        bus_io.slice_cin_c = (cnt_q == '0) ? sub_q : carry_q;
        carry_d = bus_io.slice_cout;
        cnt_d   = cnt_q + CW'(1);
        case (cnt_q)
          2'd0:    acc_d[3:0]  = bus_io.slice_sum;
          2'd1:    acc_d[7:4]  = bus_io.slice_sum;
          2'd2:    acc_d[11:8] = bus_io.slice_sum;
          default: acc_d       = acc_q;
        endcase
        if (cnt_q == 2'd3) begin
          // Top slice settles directly into the result registers.
          state_d = DONE;
          sum_d   = {bus_io.slice_sum, acc_q};
          cout_d  = bus_io.slice_cout;
          ovf_d   = (a_q[W-1] == b_msb) && (bus_io.slice_sum[NW-1] != a_q[W-1]);
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (!bus_io.run) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign bus_io.sum      = sum_q;
  assign bus_io.cout     = cout_q;
  assign bus_io.overflow = ovf_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
endmodule
